// File: rtl/tag_array_pkg.sv
// rtl/tag_array_pkg.sv - shared types and helpers for the parametrised tag array
// Purpose: sequencer state encoding, even-parity function, lane-slice helper.
// Ports: none (package).
package tag_array_pkg;

  // Explicit one-bit encoding keeps the state register layout fixed.
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Widest tag lane the parity helper covers; narrower lanes are zero-extended,
  // which does not change even parity.
  localparam int PAR_MAX_W = 64;

  function automatic logic par(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

  // Bit offset of lane 'lane' in a packed WAYS*width bus.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/tag_array_way.sv
// rtl/tag_array_way.sv - one way of tag storage with parity
// Purpose: SETS x (TAG_W+1) flop storage, synchronous write, registered read
//          with parity check.
// Ports:
//   clock, reset_n       clock and asynchronous active-low reset
//   we, waddr, wdata     write enable, set index, tag data
//   wpar_inv             invert the generated parity bit on this write
//   re, raddr            read enable, set index
//   rdata, rperr         registered read tag and parity-error flag
module tag_array_way
  import tag_array_pkg::*;
#(
  parameter int SETS  = 64,
  parameter int TAG_W = 22,
  localparam int AW   = $clog2(SETS)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [TAG_W-1:0] wdata,
  input  logic             wpar_inv,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [TAG_W-1:0] rdata,
  output logic             rperr
);

  // Bit TAG_W holds the parity; contents are initialised by the clear sequencer.
  logic [TAG_W:0] mem [SETS];
  logic [TAG_W:0] rd_word;

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= {par(PAR_MAX_W'(wdata)) ^ wpar_inv, wdata};
    end
  end

  assign rd_word = mem[raddr];

  // Response registers only load on a read, so later writes/clears leave them alone.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
      rperr <= 1'b0;
    end else if (re) begin
      rdata <= rd_word[TAG_W-1:0];
      rperr <= ^rd_word;
    end
  end

endmodule

// File: rtl/tag_array_param.sv
// rtl/tag_array_param.sv - parametrised self-initialising N-way cache tag store
// Purpose: WAYS ways of tag storage with per-way parity, a CLEAR/IDLE sequencer
//          that zeroes every set after reset and on flush, and a registered
//          read response with a one-cycle valid strobe.
// Ports:
//   clock, reset_n                         clock, asynchronous active-low reset
//   req_valid, req_ready, req_addr         request handshake and set index
//   req_wmode, req_wdata, req_wmask        write select, packed lanes, way enables
//   inj_perr                               force bad parity on masked-in write lanes
//   flush_req                              invalidate the whole array
//   busy                                   clear sequence running
//   resp_valid, resp_rdata, resp_perr      read response strobe, lanes, parity errors
module tag_array_param
  import tag_array_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int SETS  = 64,
  parameter int TAG_W = 22,
  localparam int AW   = $clog2(SETS)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [AW-1:0]         req_addr,
  input  logic                  req_wmode,
  input  logic [WAYS*TAG_W-1:0] req_wdata,
  input  logic [WAYS-1:0]       req_wmask,
  input  logic [WAYS-1:0]       inj_perr,
  input  logic                  flush_req,
  output logic                  busy,
  output logic                  resp_valid,
  output logic [WAYS*TAG_W-1:0] resp_rdata,
  output logic [WAYS-1:0]       resp_perr
);

  state_e        state;
  logic [AW-1:0] clr_cnt;
  logic          clearing;
  logic          accept;
  logic          wr_accept;
  logic          rd_accept;
  logic [AW-1:0] waddr;

  assign clearing  = (state == ST_CLEAR);
  assign busy      = clearing;
  // A flush in the same cycle wins over any request.
  assign req_ready = (state == ST_IDLE) && !flush_req;
  assign accept    = req_valid && req_ready;
  assign wr_accept = accept && req_wmode;
  assign rd_accept = accept && !req_wmode;
  assign waddr     = clearing ? clr_cnt : req_addr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_cnt == AW'(SETS - 1)) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (flush_req) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end
        end
        default: begin
          state   <= ST_CLEAR;
          clr_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid <= 1'b0;
    end else begin
      resp_valid <= rd_accept;
    end
  end

  for (genvar i = 0; i < WAYS; i++) begin : g_way
    logic             way_we;
    logic [TAG_W-1:0] way_wdata;
    logic             way_inv;

    // Clearing writes tag=0 with parity=0 into every way of the current set.
    assign way_we    = clearing || (wr_accept && req_wmask[i]);
    assign way_wdata = clearing ? '0 : req_wdata[lane_lsb(i, TAG_W) +: TAG_W];
    assign way_inv   = clearing ? 1'b0 : inj_perr[i];

    tag_array_way #(
      .SETS  (SETS),
      .TAG_W (TAG_W)
    ) u_way (
      .clock    (clock),
      .reset_n  (reset_n),
      .we       (way_we),
      .waddr    (waddr),
      .wdata    (way_wdata),
      .wpar_inv (way_inv),
      .re       (rd_accept),
      .raddr    (req_addr),
      .rdata    (resp_rdata[lane_lsb(i, TAG_W) +: TAG_W]),
      .rperr    (resp_perr[i])
    );
  end

endmodule

// File: tb/tb_tag_array_param.sv
// tb/tb_tag_array_param.sv - scoreboard bench for tag_array_param
module tb_tag_array_param;

  localparam int WAYS  = 4;
  localparam int SETS  = 64;
  localparam int TAG_W = 22;
  localparam int AW    = $clog2(SETS);
  localparam int DW    = WAYS * TAG_W;

  logic            clock;
  logic            reset_n;
  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   req_addr;
  logic            req_wmode;
  logic [DW-1:0]   req_wdata;
  logic [WAYS-1:0] req_wmask;
  logic [WAYS-1:0] inj_perr;
  logic            flush_req;
  logic            busy;
  logic            resp_valid;
  logic [DW-1:0]   resp_rdata;
  logic [WAYS-1:0] resp_perr;

  tag_array_param #(
    .WAYS  (WAYS),
    .SETS  (SETS),
    .TAG_W (TAG_W)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wmode  (req_wmode),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .inj_perr   (inj_perr),
    .flush_req  (flush_req),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_perr  (resp_perr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0]   data;
    logic [WAYS-1:0] perr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t last_exp;

  logic [TAG_W-1:0] m_tag [SETS][WAYS];
  logic             m_par [SETS][WAYS];

  int n_cmp = 0;
  int n_bad = 0;

  // Response monitor: every strobe must match the oldest queued expectation.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && resp_valid === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_resp: resp_valid=1 with empty scoreboard, required no response");
      end else begin
        mon_e = sb.pop_front();
        last_exp = mon_e;
        if (resp_rdata !== mon_e.data) begin
          n_bad++;
          $display("FAIL resp_rdata: got %h required %h", resp_rdata, mon_e.data);
        end
        n_cmp++;
        if (resp_perr !== mon_e.perr) begin
          n_bad++;
          $display("FAIL resp_perr: got %b required %b", resp_perr, mon_e.perr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        m_tag[s][w] = '0;
        m_par[s][w] = 1'b0;
      end
    end
  endtask

  task automatic drive_idle();
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_wmode = 1'b0;
    flush_req = 1'b0;
    req_wmask = '0;
    inj_perr  = '0;
  endtask

  task automatic issue_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [WAYS-1:0] mask, input logic [WAYS-1:0] inj);
    @(posedge clock);
    #1;
    req_valid = 1'b1;
    req_wmode = 1'b1;
    req_addr  = addr;
    req_wdata = data;
    req_wmask = mask;
    inj_perr  = inj;
    flush_req = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL write_ready: req_ready=%b required 1", req_ready);
    end
    for (int w = 0; w < WAYS; w++) begin
      if (mask[w]) begin
        m_tag[addr][w] = data[w*TAG_W +: TAG_W];
        m_par[addr][w] = (^data[w*TAG_W +: TAG_W]) ^ inj[w];
      end
    end
  endtask

  task automatic issue_read(input logic [AW-1:0] addr);
    exp_t e;
    @(posedge clock);
    #1;
    req_valid = 1'b1;
    req_wmode = 1'b0;
    req_addr  = addr;
    req_wdata = DW'({$urandom(), $urandom(), $urandom()});
    req_wmask = 4'($urandom());
    inj_perr  = 4'($urandom());
    flush_req = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL read_ready: req_ready=%b required 1", req_ready);
    end
    for (int w = 0; w < WAYS; w++) begin
      e.data[w*TAG_W +: TAG_W] = m_tag[addr][w];
      e.perr[w] = (^m_tag[addr][w]) ^ m_par[addr][w];
    end
    sb.push_back(e);
  endtask

  // Counts negedges with busy high; reports whether req_ready ever rose meanwhile.
  task automatic measure_clear(output int cnt, output int ready_hi);
    cnt = 0;
    ready_hi = 0;
    @(negedge clock);
    while (busy === 1'b1 && cnt < 200) begin
      if (req_ready !== 1'b0) ready_hi++;
      cnt++;
      @(negedge clock);
    end
  endtask

  task automatic drain_check(input string tag);
    repeat (3) @(posedge clock);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: %0d responses outstanding, required 0", tag, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset();
    int cnt, rhi;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_wmode = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = '0;
    inj_perr  = '0;
    flush_req = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if ({busy, req_ready, resp_valid} !== 3'b100) begin
      n_bad++;
      $display("FAIL reset_ctrl: busy,ready,valid=%b required 100", {busy, req_ready, resp_valid});
    end
    n_cmp++;
    if (resp_rdata !== '0 || resp_perr !== '0) begin
      n_bad++;
      $display("FAIL reset_resp: rdata=%h perr=%b required 0", resp_rdata, resp_perr);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    measure_clear(cnt, rhi);
    n_cmp++;
    if (cnt != SETS) begin
      n_bad++;
      $display("FAIL reset_clear_len: busy cycles=%0d required %0d", cnt, SETS);
    end
    n_cmp++;
    if (rhi != 0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_clear_ready: ready during clear=%0d after=%b required 0 and 1", rhi, req_ready);
    end
    model_clear();
    issue_read(AW'(SETS - 1));
    drive_idle();
    drain_check("reset_read63");
  endtask

  task automatic test_write_all();
    logic [DW-1:0] d;
    d = {22'h3FFFFF, 22'h000001, 22'h155555, 22'h3AAAAA};
    issue_write(5, d, 4'b1111, 4'b0000);
    issue_read(5);
    drive_idle();
    drain_check("write_all");
  endtask

  task automatic test_partial_mask();
    logic [DW-1:0] d;
    d = DW'({$urandom(), $urandom(), $urandom()});
    d[2*TAG_W +: TAG_W] = 22'h123456;
    issue_write(5, d, 4'b0100, 4'b0000);
    issue_read(5);
    issue_write(7, '0, 4'b0000, 4'b1111);
    issue_read(5);
    drive_idle();
    drain_check("partial_mask");
  endtask

  task automatic test_parity_inject();
    logic [DW-1:0] d;
    d = DW'({$urandom(), $urandom(), $urandom()});
    issue_write(9, d, 4'b1111, 4'b0010);
    issue_read(9);
    drive_idle();
    n_cmp++;
    if (sb.size() != 0 || resp_perr !== 4'b0010) begin
      @(negedge clock);
    end
    repeat (2) @(posedge clock);
    #1;
    if (resp_perr !== 4'b0010) begin
      n_bad++;
      $display("FAIL parity_inject: perr=%b required 0010", resp_perr);
    end
    issue_write(9, d, 4'b1111, 4'b0000);
    issue_read(9);
    issue_write(9, ~d, 4'b0001, 4'b0010);
    issue_read(9);
    drive_idle();
    drain_check("parity_inject");
  endtask

  task automatic test_flush();
    int cnt, rhi;
    logic [DW-1:0] held;
    held = last_exp.data;
    @(posedge clock);
    #1;
    req_valid = 1'b1;
    req_wmode = 1'b0;
    req_addr  = 5;
    flush_req = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (req_ready !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_same_cycle: ready=%b busy=%b required 0 0", req_ready, busy);
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    flush_req = 1'b0;
    measure_clear(cnt, rhi);
    n_cmp++;
    if (cnt != SETS || rhi != 0) begin
      n_bad++;
      $display("FAIL flush_clear_len: busy cycles=%0d ready_hi=%0d required %0d 0", cnt, rhi, SETS);
    end
    n_cmp++;
    if (resp_rdata !== held) begin
      n_bad++;
      $display("FAIL flush_hold: rdata=%h required %h", resp_rdata, held);
    end
    model_clear();
    issue_read(5);
    issue_read(9);
    drive_idle();
    drain_check("flush");
  endtask

  task automatic test_back_to_back();
    int cnt, rhi;
    @(posedge clock);
    #1;
    flush_req = 1'b1;
    @(posedge clock);
    #1;
    flush_req = 1'b0;
    repeat (29) @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (busy !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== '0 || resp_perr !== '0) begin
      n_bad++;
      $display("FAIL midclear_reset: busy=%b valid=%b rdata=%h perr=%b required 1 0 0 0",
               busy, resp_valid, resp_rdata, resp_perr);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    measure_clear(cnt, rhi);
    n_cmp++;
    if (cnt != SETS || rhi != 0) begin
      n_bad++;
      $display("FAIL midclear_len: busy cycles=%0d ready_hi=%0d required %0d 0", cnt, rhi, SETS);
    end
    model_clear();
    for (int k = 0; k < 12; k++) begin
      issue_write(AW'($urandom_range(0, SETS - 1)), DW'({$urandom(), $urandom(), $urandom()}),
                  4'($urandom()), 4'($urandom()));
    end
    for (int s = 0; s < SETS; s++) begin
      issue_read(AW'(s));
    end
    issue_write(3, DW'({$urandom(), $urandom(), $urandom()}), 4'b1010, 4'b0000);
    issue_read(3);
    issue_read(3);
    drive_idle();
    drain_check("back_to_back");
  endtask

  initial begin
    last_exp.data = '0;
    last_exp.perr = '0;
    model_clear();
    test_reset();
    test_write_all();
    test_partial_mask();
    test_parity_inject();
    test_flush();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
